video_sprite_multi_anim_gen: RTL and testbench

- Multi-channel successor to the single-sprite animation generator.
- Overlays NUM_SPRITE independently placed, animated sprites onto the incoming VGA pixel stream, with fixed priority (channel 0 on top).
- Each channel has its own frame RAM and its own animation sequencer, with loop, ping-pong and one-shot modes.
- Frame advance is counted in video frames, not clocks.
- Sits in the sprite core between the background generator and the output mux, with a fixed 2-cycle pixel latency.

---
 rtl/video_sprite_pkg.sv | 7 +
 rtl/video_sprite_anim_seq.sv | 65 ++++++
 rtl/video_sprite_ram.sv | 21 ++
 rtl/video_sprite_multi_anim_gen.sv | 111 +++++++++++
 tb/tb_video_sprite_multi_anim_gen.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/video_sprite_pkg.sv
// video_sprite_pkg: shared enums and default address widths for the multi-sprite animation generator
package video_sprite_pkg;
  typedef enum logic [1:0] {LOOP, PINGPONG, ONESHOT, HOLD} sprite_mode_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;
  localparam int SPRITE_AW = $clog2(32 * 32);
  localparam int SPRITE_RAM_AW = SPRITE_AW + 2;
endpackage

// File: rtl/video_sprite_anim_seq.sv
// video_sprite_anim_seq: per-channel frame sequencer (loop, ping-pong, one-shot, hold) stepped by frame_start
module video_sprite_anim_seq
  import video_sprite_pkg::*;
#(
  parameter int FRAME_NUM  = 4,
  parameter int FRAME_IDXW = 2,
  parameter int RATE_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start_i,
  input  logic                  en_i,
  input  logic [1:0]            mode_i,
  input  logic [RATE_W-1:0]     rate_i,
  output logic [FRAME_IDXW-1:0] frame_idx_o,
  output logic                  done_o
);
  localparam logic [FRAME_IDXW-1:0] LAST = FRAME_IDXW'(FRAME_NUM - 1);
  seq_state_e            state_q;
  sprite_mode_e          mode;
  logic [RATE_W-1:0]     cnt_q;
  logic [FRAME_IDXW-1:0] idx_q;
  logic                  down_q, done_q, last, pp_down;
  assign mode    = sprite_mode_e'(mode_i);
  assign last    = idx_q == LAST;
  assign pp_down = down_q ? idx_q != '0 : last;
  // sequencer FSM: disabling the channel always drops it back to IDLE with cleared state
  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      down_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= RUN;
        RUN: if (frame_start_i && mode != HOLD) begin
          if (cnt_q >= rate_i) begin
            cnt_q <= '0;
            case (mode)
              LOOP: idx_q <= last ? '0 : idx_q + 1'b1;
              PINGPONG: if (FRAME_NUM > 1) begin
                idx_q  <= pp_down ? idx_q - 1'b1 : idx_q + 1'b1;
                down_q <= pp_down;
              end
              ONESHOT: if (last) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else idx_q <= idx_q + 1'b1;
              default: ;
            endcase
          end else cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          idx_q  <= LAST;
          done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign frame_idx_o = idx_q;
  assign done_o      = done_q;
endmodule

// File: rtl/video_sprite_ram.sv
// video_sprite_ram: one-write one-read sprite frame RAM, registered read, read-before-write
module video_sprite_ram #(
  parameter int DW = 12,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_w_i,
  input  logic [DW-1:0] din_i,
  input  logic [AW-1:0] addr_r_i,
  output logic [DW-1:0] dout_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] dout_q;
  // write port and registered read port; a same-address read sees the old word
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_w_i] <= din_i;
    dout_q <= mem_q[addr_r_i];
  end
  assign dout_o = dout_q;
endmodule

// File: rtl/video_sprite_multi_anim_gen.sv
// video_sprite_multi_anim_gen: NUM_SPRITE chroma-keyed animated sprites over the pixel stream, 2-cycle latency; SPRITE_MIRROR_EN adds per-channel horizontal flip
module video_sprite_multi_anim_gen
  import video_sprite_pkg::*;
#(
  parameter int RGB_SIZE     = 12,
  parameter int NUM_SPRITE   = 4,
  parameter int SPRITE_HSIZE = 32,
  parameter int SPRITE_VSIZE = 32,
  parameter int FRAME_NUM    = 4,
  parameter int FRAME_IDXW   = 2,
  parameter int RATE_W       = 8,
  parameter int H_SIZE       = 10,
  parameter int V_SIZE       = 10,
  parameter logic [RGB_SIZE-1:0] KEY_COLOR = '0,
  localparam int SELW = NUM_SPRITE > 1 ? $clog2(NUM_SPRITE) : 1,
  localparam int HW   = $clog2(SPRITE_HSIZE),
  localparam int VW   = $clog2(SPRITE_VSIZE),
  localparam int AW   = FRAME_IDXW + HW + VW
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic [NUM_SPRITE-1:0]            sprite_en,
  input  logic [2*NUM_SPRITE-1:0]          sprite_mode,
  input  logic [H_SIZE*NUM_SPRITE-1:0]     sprite_x0,
  input  logic [V_SIZE*NUM_SPRITE-1:0]     sprite_y0,
  input  logic [RATE_W*NUM_SPRITE-1:0]     sprite_rate,
`ifdef SPRITE_MIRROR_EN
  input  logic [NUM_SPRITE-1:0]            sprite_mirror,
`endif
  input  logic                             sprite_ram_we,
  input  logic [SELW-1:0]                  sprite_ram_sel,
  input  logic [AW-1:0]                    sprite_ram_addr_w,
  input  logic [RGB_SIZE-1:0]              sprite_ram_din,
  input  logic [H_SIZE-1:0]                xx,
  input  logic [V_SIZE-1:0]                yy,
  input  logic [RGB_SIZE-1:0]              src_rgb,
  output logic [RGB_SIZE-1:0]              sprite_rgb,
  output logic                             sprite_hit,
  output logic [SELW-1:0]                  sprite_hit_id,
  output logic [FRAME_IDXW*NUM_SPRITE-1:0] sprite_frame_idx,
  output logic [NUM_SPRITE-1:0]            sprite_done
);
  logic [NUM_SPRITE-1:0]          region, ok_q;
  logic [RGB_SIZE*NUM_SPRITE-1:0] dout;
  logic [RGB_SIZE-1:0]            src_q, rgb_q, rgb_d;
  logic                           hit_q, hit_d;
  logic [SELW-1:0]                id_q, id_d;
  for (genvar n = 0; n < NUM_SPRITE; n++) begin : g_ch
    logic [H_SIZE:0] sx;
    logic [V_SIZE:0] sy;
    logic [HW-1:0]   rx;
    assign sx = {1'b0, xx} - {1'b0, sprite_x0[n*H_SIZE +: H_SIZE]};
    assign sy = {1'b0, yy} - {1'b0, sprite_y0[n*V_SIZE +: V_SIZE]};
    assign region[n] = sx[H_SIZE:HW] == '0 && sy[V_SIZE:VW] == '0;
`ifdef SPRITE_MIRROR_EN
    assign rx = sprite_mirror[n] ? ~sx[HW-1:0] : sx[HW-1:0];
`else
    assign rx = sx[HW-1:0];
`endif
    video_sprite_ram #(.DW(RGB_SIZE), .AW(AW)) u_ram (
      .clk      (clk),
      .we_i     (sprite_ram_we && sprite_ram_sel == SELW'(n)),
      .addr_w_i (sprite_ram_addr_w),
      .din_i    (sprite_ram_din),
      .addr_r_i ({sprite_frame_idx[n*FRAME_IDXW +: FRAME_IDXW], sy[VW-1:0], rx}),
      .dout_o   (dout[n*RGB_SIZE +: RGB_SIZE])
    );
    video_sprite_anim_seq #(.FRAME_NUM(FRAME_NUM), .FRAME_IDXW(FRAME_IDXW), .RATE_W(RATE_W)) u_seq (
      .clk           (clk),
      .rst           (rst),
      .frame_start_i (frame_start),
      .en_i          (sprite_en[n]),
      .mode_i        (sprite_mode[2*n +: 2]),
      .rate_i        (sprite_rate[n*RATE_W +: RATE_W]),
      .frame_idx_o   (sprite_frame_idx[n*FRAME_IDXW +: FRAME_IDXW]),
      .done_o        (sprite_done[n])
    );
  end
  // fixed priority: scan from the highest channel down so the lowest opaque hit wins
  always_comb begin
    rgb_d = src_q;
    hit_d = 1'b0;
    id_d  = '0;
    for (int i = NUM_SPRITE - 1; i >= 0; i--)
      if (ok_q[i] && dout[i*RGB_SIZE +: RGB_SIZE] != KEY_COLOR) begin
        rgb_d = dout[i*RGB_SIZE +: RGB_SIZE];
        hit_d = 1'b1;
        id_d  = SELW'(i);
      end
  end
  // stage 1 aligns region/background with RAM data, stage 2 registers the blend
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_q  <= '0;
      src_q <= '0;
      rgb_q <= '0;
      hit_q <= 1'b0;
      id_q  <= '0;
    end else begin
      ok_q  <= region & sprite_en;
      src_q <= src_rgb;
      rgb_q <= rgb_d;
      hit_q <= hit_d;
      id_q  <= id_d;
    end
  end
  assign sprite_rgb    = rgb_q;
  assign sprite_hit    = hit_q;
  assign sprite_hit_id = id_q;
endmodule

// File: tb/tb_video_sprite_multi_anim_gen.sv
// tb_video_sprite_multi_anim_gen: randomized directed bench against a frame-count reference model
module tb_video_sprite_multi_anim_gen;
  logic        clk = 1'b0, rst, frame_start;
  logic [3:0]  sprite_en;
  logic [7:0]  sprite_mode;
  logic [39:0] sprite_x0, sprite_y0;
  logic [31:0] sprite_rate;
  logic        sprite_ram_we;
  logic [1:0]  sprite_ram_sel;
  logic [11:0] sprite_ram_addr_w, sprite_ram_din;
  logic [9:0]  xx, yy;
  logic [11:0] src_rgb, sprite_rgb;
  logic        sprite_hit;
  logic [1:0]  sprite_hit_id;
  logic [7:0]  sprite_frame_idx;
  logic [3:0]  sprite_done;
  logic [11:0] mem [4][4096];
  int x0[4], y0[4], md[4], rt[4], fs[4];
  bit en[4];
  int errs = 0, checks = 0;

  video_sprite_multi_anim_gen dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .sprite_en(sprite_en),
    .sprite_mode(sprite_mode), .sprite_x0(sprite_x0), .sprite_y0(sprite_y0),
    .sprite_rate(sprite_rate), .sprite_ram_we(sprite_ram_we), .sprite_ram_sel(sprite_ram_sel),
    .sprite_ram_addr_w(sprite_ram_addr_w), .sprite_ram_din(sprite_ram_din), .xx(xx), .yy(yy),
    .src_rgb(src_rgb), .sprite_rgb(sprite_rgb), .sprite_hit(sprite_hit),
    .sprite_hit_id(sprite_hit_id), .sprite_frame_idx(sprite_frame_idx), .sprite_done(sprite_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int steps(int c);
    return fs[c] / (rt[c] + 1);
  endfunction

  function automatic int ref_idx(int c);
    int s, p;
    if (!en[c]) return 0;
    s = steps(c);
    p = s % 6;
    case (md[c])
      0: return s % 4;
      1: return p <= 3 ? p : 6 - p;
      2: return s >= 4 ? 3 : s;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_done(int c);
    return (en[c] && md[c] == 2 && steps(c) >= 4) ? 1 : 0;
  endfunction

  task automatic ref_pix(int x, int y, int src, output int rgb, output int hit, output int id);
    rgb = src; hit = 0; id = 0;
    for (int c = 3; c >= 0; c--)
      if (en[c] && x >= x0[c] && x < x0[c] + 32 && y >= y0[c] && y < y0[c] + 32 &&
          mem[c][ref_idx(c) * 1024 + (y - y0[c]) * 32 + (x - x0[c])] != 0) begin
        rgb = mem[c][ref_idx(c) * 1024 + (y - y0[c]) * 32 + (x - x0[c])];
        hit = 1;
        id  = c;
      end
  endtask

  task automatic apply_cfg;
    for (int c = 0; c < 4; c++) begin
      sprite_en[c]          = en[c];
      sprite_mode[2*c +: 2] = 2'(md[c]);
      sprite_x0[10*c +: 10] = 10'(x0[c]);
      sprite_y0[10*c +: 10] = 10'(y0[c]);
      sprite_rate[8*c +: 8] = 8'(rt[c]);
    end
  endtask

  task automatic wr(int c, int a, int d);
    sprite_ram_we = 1'b1; sprite_ram_sel = 2'(c); sprite_ram_addr_w = 12'(a); sprite_ram_din = 12'(d);
    tick;
    sprite_ram_we = 1'b0;
    mem[c][a] = 12'(d);
  endtask

  task automatic fstart;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    for (int c = 0; c < 4; c++) if (en[c]) fs[c]++;
  endtask

  task automatic check_seq(string tag);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s_idx%0d", tag, c), 32'(sprite_frame_idx[2*c +: 2]), ref_idx(c));
      chk($sformatf("%s_done%0d", tag, c), 32'(sprite_done[c]), ref_done(c));
    end
  endtask

  task automatic pix(string tag, int x, int y);
    int src, rgb, hit, id;
    src = int'($urandom_range(0, 4095));
    ref_pix(x, y, src, rgb, hit, id);
    xx = 10'(x); yy = 10'(y); src_rgb = 12'(src);
    tick;
    xx = 10'($urandom); yy = 10'($urandom); src_rgb = 12'($urandom);
    tick;
    chk({tag, "_rgb"}, 32'(sprite_rgb), rgb);
    chk({tag, "_hit"}, 32'(sprite_hit), hit);
    chk({tag, "_id"}, 32'(sprite_hit_id), id);
  endtask

  initial begin
    int rgb, hit, id, a, guard;
    rst = 1'b1; frame_start = 1'b0; sprite_ram_we = 1'b0; sprite_ram_sel = '0;
    sprite_ram_addr_w = '0; sprite_ram_din = '0; xx = '0; yy = '0; src_rgb = '0;
    sprite_en = '0; sprite_mode = '0; sprite_x0 = '0; sprite_y0 = '0; sprite_rate = '0;
    repeat (3) tick;
    chk("rst_rgb", 32'(sprite_rgb), 0);
    chk("rst_hit", 32'(sprite_hit), 0);
    chk("rst_id", 32'(sprite_hit_id), 0);
    chk("rst_idx", 32'(sprite_frame_idx), 0);
    chk("rst_done", 32'(sprite_done), 0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4096; i++)
        wr(c, i, c == 0 ? i / 1024 + 1 :
                 ($urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 4095))));
    x0 = '{100, 110, 0, 300}; y0 = '{50, 60, 0, 200};
    md = '{0, 1, 2, 0};       rt = '{2, 0, 0, int'($urandom_range(0, 3))};
    en = '{1, 1, 1, 1};       fs = '{0, 0, 0, 0};
    apply_cfg;
    tick; tick;
    check_seq("start");
    pix("origin", 100, 50);
    for (int f = 0; f < 4; f++) wr(2, f * 1024, 12'h5a5);
    pix("x0zero", 0, 0);
    for (int i = 0; i < 14; i++) begin
      fstart;
      check_seq("anim");
      pix("anim_origin", 100, 50);
      pix("anim_rnd", int'($urandom_range(0, 340)), int'($urandom_range(0, 240)));
    end
    pix("left", 99, 50);
    pix("right", 132, 50);
    pix("below", 100, 82);
    for (int f = 0; f < 4; f++) wr(1, f * 1024, 12'h3c3);
    pix("prio0", 110, 60);
    for (int f = 0; f < 4; f++) wr(0, f * 1024 + 330, 0);
    pix("prio1", 110, 60);
    a = ref_idx(0) * 1024 + 1;
    ref_pix(101, 50, 12'h123, rgb, hit, id);
    xx = 10'd101; yy = 10'd50; src_rgb = 12'h123;
    sprite_ram_we = 1'b1; sprite_ram_sel = 2'd0; sprite_ram_addr_w = 12'(a); sprite_ram_din = 12'h777;
    tick;
    sprite_ram_we = 1'b0; mem[0][a] = 12'h777;
    tick;
    chk("rw_old_rgb", 32'(sprite_rgb), rgb);
    pix("rw_new", 101, 50);
    en[2] = 0; fs[2] = 0;
    apply_cfg;
    tick;
    chk("dis_idx2", 32'(sprite_frame_idx[5:4]), 0);
    chk("dis_done2", 32'(sprite_done[2]), 0);
    pix("dis_pix", 0, 0);
    guard = 0;
    while (ref_idx(0) != 2 && guard < 12) begin
      fstart;
      guard++;
    end
    chk("pre_rst_idx0", 32'(sprite_frame_idx[1:0]), 2);
    rst = 1'b1;
    tick;
    chk("mid_rst_rgb", 32'(sprite_rgb), 0);
    chk("mid_rst_hit", 32'(sprite_hit), 0);
    chk("mid_rst_id", 32'(sprite_hit_id), 0);
    chk("mid_rst_idx", 32'(sprite_frame_idx), 0);
    chk("mid_rst_done", 32'(sprite_done), 0);
    rst = 1'b0; fs = '{0, 0, 0, 0};
    tick; tick;
    pix("after_rst", 100, 50);
    check_seq("after_rst");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
